// File: rtl/instr_fetch_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_ctrl_if
// Brief    : Fetch-side bundle: redirect input, instruction memory read port,
//            decode valid/ready handshake and fault flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_valid_in;
  logic [ADDR_WIDTH-1:0] redirect_pc_in;
  logic [ADDR_WIDTH-1:0] imem_addr_out;
  logic [DATA_WIDTH-1:0] imem_instr_in;
  logic                  fetch_valid_out;
  logic                  fetch_ready_in;
  logic [ADDR_WIDTH-1:0] fetch_pc_out;
  logic [DATA_WIDTH-1:0] fetch_instr_out;
  logic                  fault_out;

  // Fetch controller side
  modport master (
    input  redirect_valid_in, redirect_pc_in, imem_instr_in, fetch_ready_in,
    output imem_addr_out, fetch_valid_out, fetch_pc_out, fetch_instr_out, fault_out
  );

  // Environment side: execute, instruction memory and decode
  modport slave (
    output redirect_valid_in, redirect_pc_in, imem_instr_in, fetch_ready_in,
    input  imem_addr_out, fetch_valid_out, fetch_pc_out, fetch_instr_out, fault_out
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_ctrl
// Brief    : Program counter owner and fetch sequencer. Reads one instruction
//            per cycle from a combinational memory port, buffers up to two
//            {pc, instr} pairs and hands them to decode over valid/ready.
//            Optional macro FETCH_FAULT_EN enables misaligned/out-of-range
//            fetch address detection with a sticky fault state.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH    = 64,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MEM_DEPTH_POW = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  instr_fetch_ctrl_if.master  bus
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FAULT = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [1:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_q_pc    [0:1];
  logic [DATA_WIDTH-1:0] r_q_instr [0:1];

  logic w_run;
  logic w_fault_flag;
  logic w_fault_detect;
  logic w_pop;
  logic w_push;
  logic w_wr_idx;

  // Address legality check; without the feature every address is fetched as-is
`ifdef FETCH_FAULT_EN
  assign w_fault_detect = (r_pc[1:0] != 2'b00) |
                          (|r_pc[ADDR_WIDTH-1:MEM_DEPTH_POW+2]);
`else
  assign w_fault_detect = 1'b0;
`endif

  assign w_pop  = (r_count != 2'd0) & bus.fetch_ready_in;
  assign w_push = w_run & ~bus.redirect_valid_in & ~w_fault_detect &
                  ((r_count != 2'd2) | w_pop);
  // Tail slot: a simultaneous pop shifts the queue down by one first
  assign w_wr_idx = w_pop ? (r_count == 2'd2) : (r_count == 2'd1);

  assign bus.imem_addr_out   = r_pc;
  assign bus.fetch_valid_out = (r_count != 2'd0);
  assign bus.fetch_pc_out    = r_q_pc[0];
  assign bus.fetch_instr_out = r_q_instr[0];
  assign bus.fault_out       = w_fault_flag;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: redirect always returns to RUN, a bad address traps
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect_valid_in)
      w_state_nxt = S_RUN;
    else if ((r_state == S_RUN) && w_fault_detect)
      w_state_nxt = S_FAULT;
  end

  // FSM outputs: fetch enable and held fault flag
  always_comb begin
    w_run        = (r_state == S_RUN);
`ifdef FETCH_FAULT_EN
    w_fault_flag = (r_state == S_FAULT);
`else
    w_fault_flag = 1'b0;
`endif
  end

  // PC and skid FIFO; redirect flushes and wins over any same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_count      <= 2'd0;
      r_q_pc[0]    <= '0;
      r_q_pc[1]    <= '0;
      r_q_instr[0] <= '0;
      r_q_instr[1] <= '0;
    end else if (bus.redirect_valid_in) begin
      r_pc    <= bus.redirect_pc_in;
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_q_pc[0]    <= r_q_pc[1];
        r_q_instr[0] <= r_q_instr[1];
      end
      if (w_push) begin
        r_q_pc[w_wr_idx]    <= r_pc;
        r_q_instr[w_wr_idx] <= bus.imem_instr_in;
        r_pc                <= r_pc + ADDR_WIDTH'(4);
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_fetch_ctrl
// Brief    : Directed self-checking bench for instr_fetch_ctrl with a
//            combinational instruction memory model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

  instr_fetch_ctrl #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .MEM_DEPTH_POW(10), .RESET_PC(64'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory word n holds 0xC0DE0000 | n, indexed by address bits [11:2]
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 | {22'd0, a[11:2]};
  endfunction

  assign bus.imem_instr_in = mem_word(bus.imem_addr_out);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc);
    chk({tag, "_valid"}, {63'd0, bus.fetch_valid_out}, 64'd1);
    chk({tag, "_pc"}, bus.fetch_pc_out, pc);
    chk({tag, "_instr"}, {32'd0, bus.fetch_instr_out}, {32'd0, mem_word(pc)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] h;
    bus.redirect_valid_in = 1'b0;
    bus.redirect_pc_in    = '0;
    bus.fetch_ready_in    = 1'b0;

    // Reset state
    step(); step();
    chk("rst_valid", {63'd0, bus.fetch_valid_out}, 64'd0);
    chk("rst_pc",    bus.fetch_pc_out, 64'd0);
    chk("rst_instr", {32'd0, bus.fetch_instr_out}, 64'd0);
    chk("rst_fault", {63'd0, bus.fault_out}, 64'd0);
    chk("rst_addr",  bus.imem_addr_out, 64'd0);

    // Streaming with ready high: 0x0, 0x4, 0x8
    rst = 1'b0;
    bus.fetch_ready_in = 1'b1;
    step(); chk_head("s0", 64'h0); chk("s0_addr", bus.imem_addr_out, 64'h4);
    step(); chk_head("s1", 64'h4);
    step(); chk_head("s2", 64'h8);

    // Backpressure: FIFO fills to 2 and PC stalls
    bus.fetch_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_head("bp", 64'h8);
      if (i >= 1) chk("bp_addr", bus.imem_addr_out, 64'h10);
    end

    // Release: full FIFO with push+pop each cycle, PCs strictly +4
    bus.fetch_ready_in = 1'b1;
    h = 64'h8;
    for (int i = 0; i < 12; i++) begin
      step();
      h = h + 64'd4;
      chk_head("pp", h);
      chk("pp_addr", bus.imem_addr_out, h + 64'd8);
    end

    // Redirect while full with a pop pending: flush wins
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 64'h100;
    step();
    bus.redirect_valid_in = 1'b0;
    chk("rd_valid", {63'd0, bus.fetch_valid_out}, 64'd0);
    chk("rd_addr",  bus.imem_addr_out, 64'h100);
    step(); chk_head("rd_t", 64'h100);
    step(); chk_head("rd_t2", 64'h104);

    // Misaligned target
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 64'h102;
    step();
    bus.redirect_valid_in = 1'b0;
    chk("ma_valid", {63'd0, bus.fetch_valid_out}, 64'd0);
    chk("ma_fault0", {63'd0, bus.fault_out}, 64'd0);
`ifdef FETCH_FAULT_EN
    step();
    chk("ma_fault", {63'd0, bus.fault_out}, 64'd1);
    chk("ma_valid1", {63'd0, bus.fetch_valid_out}, 64'd0);
    chk("ma_addr", bus.imem_addr_out, 64'h102);
    step();
    chk("ma_hold", {63'd0, bus.fault_out}, 64'd1);
    chk("ma_valid2", {63'd0, bus.fetch_valid_out}, 64'd0);
    chk("ma_addr2", bus.imem_addr_out, 64'h102);
    // Clear by redirect to 0
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 64'h0;
    step();
    bus.redirect_valid_in = 1'b0;
    chk("clr_fault", {63'd0, bus.fault_out}, 64'd0);
    step(); chk_head("clr_t", 64'h0);
    // Out of range target
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 64'h1000;
    step();
    bus.redirect_valid_in = 1'b0;
    step();
    chk("oor_fault", {63'd0, bus.fault_out}, 64'd1);
    chk("oor_valid", {63'd0, bus.fetch_valid_out}, 64'd0);
    chk("oor_addr", bus.imem_addr_out, 64'h1000);
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 64'h0;
    step();
    bus.redirect_valid_in = 1'b0;
    step(); chk_head("oor_clr", 64'h0);
    chk("oor_clr_fault", {63'd0, bus.fault_out}, 64'd0);
`else
    // Without fault detection the misaligned address is fetched unchanged
    step(); chk_head("ma_t", 64'h102);
    chk("ma_nofault", {63'd0, bus.fault_out}, 64'd0);
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 64'h1000;
    step();
    bus.redirect_valid_in = 1'b0;
    step(); chk_head("oor_t", 64'h1000);
    chk("oor_nofault", {63'd0, bus.fault_out}, 64'd0);
`endif

    // Reset mid-stream
    step(); chk("pre_rst_valid", {63'd0, bus.fetch_valid_out}, 64'd1);
    rst = 1'b1;
    bus.redirect_valid_in = 1'b1;
    bus.redirect_pc_in    = 64'h200;
    step();
    chk("mr_valid", {63'd0, bus.fetch_valid_out}, 64'd0);
    chk("mr_fault", {63'd0, bus.fault_out}, 64'd0);
    chk("mr_addr",  bus.imem_addr_out, 64'h0);
    chk("mr_pc",    bus.fetch_pc_out, 64'h0);
    bus.redirect_valid_in = 1'b0;
    rst = 1'b0;
    step(); chk_head("mr_t", 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch sequencer that owns the program counter and drives the combinational instruction memory read port. Each cycle it reads one 32-bit instruction at the current PC, buffers up to two {pc, instr} pairs in a skid FIFO, and presents them to decode over a valid/ready handshake. It accepts redirects (branch/jump/trap) from execute and optionally flags illegal fetch addresses.

## Interface
- ADDR_WIDTH, 64: PC and memory address width.
- DATA_WIDTH, 32: instruction width.
- MEM_DEPTH_POW, 10: log2 of instruction memory words; must match the memory instance.
- RESET_PC, 64'h0: PC loaded on reset.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- redirect_valid_in  input  1  redirect request this cycle.
- redirect_pc_in  input  ADDR_WIDTH  redirect target.
- imem_addr_out  output  ADDR_WIDTH  to instruction memory addr_in; equals pc register.
- imem_instr_in  input  DATA_WIDTH  from instruction memory instr_out; same-cycle (combinational) data.
- fetch_valid_out  output  1  FIFO head valid.
- fetch_ready_in  input  1  decode accepts head.
- fetch_pc_out  output  ADDR_WIDTH  PC of head entry.
- fetch_instr_out  output  DATA_WIDTH  instruction of head entry.
- fault_out  output  1  fetch fault held (see Configuration).

## Operation
- State: pc register, 2-entry FIFO (count 0..2), FSM {RUN, FAULT}.
- pop = fetch_valid_out & fetch_ready_in.
- push = RUN & !redirect_valid_in & !fault_detect & (count<2 | pop); push writes {pc, imem_instr_in} to tail and sets pc <= pc + 4 (modulo 2^ADDR_WIDTH).
- Redirect (any state): FIFO flushed (count <= 0), pc <= redirect_pc_in, state <= RUN, fault_out cleared. No push, and any simultaneous pop is discarded (flush takes priority).
- Full FIFO with pop in same cycle: push and pop both occur, count stays 2, order preserved.
- Full FIFO without pop: pc holds, no push; imem_addr_out stays stable.
- FAULT: no pushes, pc holds; FIFO continues draining to decode. Exit only by redirect or rst.
- Head outputs are registered FIFO contents; fetch_pc_out/fetch_instr_out hold stable while fetch_valid_out & !fetch_ready_in.

## Timing
- Reset (rst high at edge): pc = RESET_PC, count = 0, state = RUN, fetch_valid_out = 0, fetch_pc_out = 0, fetch_instr_out = 0, fault_out = 0. imem_addr_out = RESET_PC.
- First edge with rst low: instruction at RESET_PC pushed; fetch_valid_out = 1 the following cycle (1-cycle fetch latency).
- Steady state with fetch_ready_in held high: one instruction per cycle, consecutive PCs +4.
- Redirect at edge N: fetch_valid_out = 0 during cycle N+1; first target instruction valid in cycle N+2.
- rst mid-operation overrides redirect and all handshakes; FIFO contents discarded.

## Configuration
- FETCH_FAULT_EN defined: fault_detect = (pc[1:0] != 0) | (pc >> 2 >= 2^MEM_DEPTH_POW), evaluated in RUN. On detect: no push, state <= FAULT, fault_out <= 1 next edge, pc holds faulting address (visible on imem_addr_out).
- FETCH_FAULT_EN undefined: fault_detect = 0, FAULT state unreachable, fault_out tied 0; misaligned low bits passed to memory unchanged, out-of-range addresses wrap per memory indexing.

## Test plan
- Reset then fetch_ready_in = 1, RESET_PC = 0: fetch_pc_out sequence 0x0, 0x4, 0x8 on consecutive cycles starting 1 cycle after reset release, instr matches memory words 0,1,2.
- Backpressure: ready = 0 for 5 cycles after first valid -> count saturates at 2, pc stalls at 0x8, head stays 0x0; ready = 1 -> 0x0, 0x4, 0x8 emitted, no loss or duplicate.
- Redirect to 0x100 while FIFO full and ready = 1 same cycle -> pop discarded, next cycle valid = 0, following cycle head pc = 0x100.
- Simultaneous push and pop at count = 2 for 10 cycles -> count stays 2, PCs strictly +4.
- FETCH_FAULT_EN: redirect to 0x102 -> fault_out = 1 after 1 edge, valid stays 0, imem_addr_out = 0x102; redirect to 0x0 clears fault and resumes. Also redirect to 0x1000 (MEM_DEPTH_POW = 10) -> fault.
- rst asserted mid-stream with valid = 1 -> next cycle valid = 0, fault_out = 0, imem_addr_out = RESET_PC.
